// File: rtl/if_id_buffer.sv
// Two-entry elastic IF/ID buffer: captures fetched PC/instruction, precomputes PC+4,
// and presents the oldest entry to decode under a valid/ready handshake.
module if_id_buffer #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc4
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned CNTW = 2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
    } entry_t;

    localparam entry_t EMPTY_ENTRY = '{
        pc:    RESET_PC,
        instr: NOP_INSTR,
        pc4:   RESET_PC + XLEN'(4)
    };

    logic [CNTW-1:0] count_q, count_d;
    entry_t          head_q, head_d;
    entry_t          tail_q, tail_d;
    entry_t          in_entry;
    logic            push;
    logic            pop;

    // Handshake status depends only on registered occupancy.
    assign in_ready  = (count_q != CNTW'(2)) & rst_n;
    assign out_valid = (count_q != CNTW'(0));
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign in_entry = '{pc: in_pc, instr: in_instr, pc4: in_pc + XLEN'(4)};

    // Head is rewritten to the empty pattern whenever the buffer drains,
    // so the outputs can be driven straight from the head register.
    assign out_pc    = head_q.pc;
    assign out_instr = head_q.instr;
    assign out_pc4   = head_q.pc4;

    // Next-state logic for occupancy and the two entries.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = CNTW'(0);
            head_d  = EMPTY_ENTRY;
            tail_d  = EMPTY_ENTRY;
        end else begin
            unique case (count_q)
                CNTW'(0): begin
                    if (push) begin
                        head_d  = in_entry;
                        count_d = CNTW'(1);
                    end
                end
                CNTW'(1): begin
                    if (push && pop) begin
                        head_d = in_entry;
                    end else if (push) begin
                        tail_d  = in_entry;
                        count_d = CNTW'(2);
                    end else if (pop) begin
                        head_d  = EMPTY_ENTRY;
                        count_d = CNTW'(0);
                    end
                end
                CNTW'(2): begin
                    if (pop) begin
                        head_d  = tail_q;
                        tail_d  = EMPTY_ENTRY;
                        count_d = CNTW'(1);
                    end
                end
                default: begin
                    count_d = CNTW'(0);
                    head_d  = EMPTY_ENTRY;
                    tail_d  = EMPTY_ENTRY;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= CNTW'(0);
            head_q  <= EMPTY_ENTRY;
            tail_q  <= EMPTY_ENTRY;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: directed vectors plus a random valid/ready soak
// checked against a reference FIFO queue.
module tb_if_id_buffer;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_1000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = 32'h0;
    logic [31:0] in_instr = 32'h0;
    logic [31:0] exp_pc4 = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;

    int   n_vec  = 0;
    int   n_miss = 0;
    bit   armed  = 1'b0;
    ent_t q[$];

    if_id_buffer #(.NOP_INSTR(NOP_INSTR), .RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_pc4   (out_pc4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT against the queue head, then advance the model for the next edge.
    always @(negedge clk) begin
        if (armed) begin
            bit mrdy;
            bit mpop;
            bit mpush;
            mrdy = (q.size() < 2) && rst_n;
            chk("in_ready", 32'(in_ready), 32'(mrdy));
            if (q.size() == 0) begin
                chk("out_valid_empty", 32'(out_valid), 32'd0);
                chk("out_pc_empty", out_pc, RESET_PC);
                chk("out_instr_empty", out_instr, NOP_INSTR);
                chk("out_pc4_empty", out_pc4, RESET_PC + 32'd4);
            end else begin
                chk("out_valid", 32'(out_valid), 32'd1);
                chk("out_pc", out_pc, q[0].pc);
                chk("out_instr", out_instr, q[0].instr);
                chk("out_pc4", out_pc4, q[0].pc4);
            end
            if (!rst_n || flush) begin
                q.delete();
            end else begin
                mpop  = (q.size() != 0) && out_ready;
                mpush = in_valid && mrdy;
                if (mpop) void'(q.pop_front());
                if (mpush) q.push_back('{pc: in_pc, instr: in_instr, pc4: exp_pc4});
            end
        end
    end

    // One stimulus beat, applied just after a rising edge and sampled at the next one.
    task automatic beat(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] pc4, input bit ordy, input bit fl, input bit rn);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        exp_pc4   = pc4;
        out_ready = ordy;
        flush     = fl;
        rst_n     = rn;
    endtask

    task automatic idle(input bit ordy);
        beat(1'b0, 32'h0, 32'h0, 32'h4, ordy, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset for two edges, then arm the monitor with an empty model.
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        armed = 1'b1;

        // Single push with consumer ready.
        beat(1'b1, 32'h0000_0100, 32'h8C22_0004, 32'h0000_0104, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Fill while stalled, offer a third beat, then drain in order.
        beat(1'b1, 32'h0000_0200, 32'h0000_1111, 32'h0000_0204, 1'b0, 1'b0, 1'b1);
        beat(1'b1, 32'h0000_0204, 32'h0000_2222, 32'h0000_0208, 1'b0, 1'b0, 1'b1);
        beat(1'b1, 32'h0000_0208, 32'h0000_3333, 32'h0000_020C, 1'b0, 1'b0, 1'b1);
        beat(1'b1, 32'h0000_0208, 32'h0000_3333, 32'h0000_020C, 1'b0, 1'b0, 1'b1);
        beat(1'b1, 32'h0000_0208, 32'h0000_3333, 32'h0000_020C, 1'b1, 1'b0, 1'b1);
        beat(1'b1, 32'h0000_0208, 32'h0000_3333, 32'h0000_020C, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Count 1 with simultaneous push and pop.
        beat(1'b1, 32'h0000_02FC, 32'h0000_4444, 32'h0000_0300, 1'b0, 1'b0, 1'b1);
        beat(1'b1, 32'h0000_0300, 32'h0000_5555, 32'h0000_0304, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // Full buffer flushed together with an incoming beat.
        beat(1'b1, 32'h0000_0380, 32'h0000_6666, 32'h0000_0384, 1'b0, 1'b0, 1'b1);
        beat(1'b1, 32'h0000_0384, 32'h0000_7777, 32'h0000_0388, 1'b0, 1'b0, 1'b1);
        beat(1'b1, 32'h0000_0400, 32'h0000_8888, 32'h0000_0404, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // PC+4 wraps modulo 2^32.
        beat(1'b1, 32'hFFFF_FFFC, 32'h0000_9999, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Reset while full.
        beat(1'b1, 32'h0000_0500, 32'h0000_AAAA, 32'h0000_0504, 1'b0, 1'b0, 1'b1);
        beat(1'b1, 32'h0000_0504, 32'h0000_BBBB, 32'h0000_0508, 1'b0, 1'b0, 1'b1);
        beat(1'b1, 32'h0000_0508, 32'h0000_CCCC, 32'h0000_050C, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b1);

        // Random valid/ready soak with occasional flush.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rpc;
            rpc = {$urandom_range(32'h3FFF_FFFF, 0), 2'b00};
            if (i == 37) rpc = 32'hFFFF_FFFC;
            beat(1'($urandom_range(1, 0)), rpc, $urandom(), rpc + 32'd4,
                 1'($urandom_range(1, 0)), ($urandom_range(19, 0) == 0), 1'b1);
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        @(posedge clk);
        #1;
        armed = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
